// File: rtl/neuron_pkg.sv
// Shared types and requantization arithmetic for the neuron activation stage.
// NEURON_ACT_RELU_EN: when defined, negative rounded results are forced to zero before clipping.
package neuron_pkg;

    localparam int unsigned ACC_W = 16;
    localparam int unsigned OUT_W = 8;

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic signed [OUT_W-1:0] act_t;

    typedef struct packed {
        logic               sat;
        logic signed [31:0] value;
    } sat_res_t;

    // Round-half-up arithmetic shift, optional ReLU, then clip to a signed out_w-bit range.
    function automatic sat_res_t sat_round(input logic signed [31:0] sum,
                                           input int unsigned        shift,
                                           input int unsigned        out_w);
        logic signed [31:0] r;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        sat_res_t           res;
        r  = (sum + (32'sd1 <<< (shift - 1))) >>> shift;
        hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (out_w - 1));
`ifdef NEURON_ACT_RELU_EN
        if (r < 0) begin
            r = 32'sd0;
        end
`endif
        res.sat   = 1'b0;
        res.value = r;
        if (r > hi) begin
            res.sat   = 1'b1;
            res.value = hi;
        end else if (r < lo) begin
            res.sat   = 1'b1;
            res.value = lo;
        end
        return res;
    endfunction

endpackage

// File: rtl/neuron_pipe_reg.sv
// Generic valid/ready pipeline register without skid buffer; accepts when empty or draining.
module neuron_pipe_reg #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] out_data_o
);

    logic             valid_d;
    logic             valid_q;
    logic [Width-1:0] data_d;
    logic [Width-1:0] data_q;

    always_comb begin
        in_ready_o = !valid_q || out_ready_i;
        valid_d    = valid_q;
        data_d     = data_q;
        if (in_ready_o) begin
            valid_d = in_valid_i;
            if (in_valid_i) begin
                data_d = in_data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

endmodule

// File: rtl/neuron_act.sv
// Post-MAC activation: bias add, rounded requantize, optional ReLU (NEURON_ACT_RELU_EN),
// signed saturation, two-stage valid/ready pipeline and a sticky saturation counter.
module neuron_act #(
    parameter int unsigned ACC_W = neuron_pkg::ACC_W,
    parameter int unsigned OUT_W = neuron_pkg::OUT_W,
    parameter int unsigned SHIFT = 6,
    parameter int unsigned CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [ACC_W-1:0] acc_in,
    input  logic signed [ACC_W-1:0] bias,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] act_out,
    output logic                    sat_flag,
    output logic        [CNT_W-1:0] sat_cnt
);

    import neuron_pkg::*;

    localparam int unsigned SumW = ACC_W + 1;

    logic signed [SumW-1:0]  sum_d;
    logic signed [SumW-1:0]  sum_q;
    logic                    s1_valid;
    logic                    s2_ready;
    sat_res_t                res;
    logic        [OUT_W:0]   s2_data_d;
    logic        [OUT_W:0]   s2_data_q;
    logic        [CNT_W-1:0] cnt_d;
    logic        [CNT_W-1:0] cnt_q;

    assign sum_d = $signed({acc_in[ACC_W-1], acc_in}) + $signed({bias[ACC_W-1], bias});

    neuron_pipe_reg #(
        .Width (SumW)
    ) u_s1 (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (sum_d),
        .out_valid_o (s1_valid),
        .out_ready_i (s2_ready),
        .out_data_o  (sum_q)
    );

    always_comb begin
        res       = sat_round(32'(sum_q), SHIFT, OUT_W);
        s2_data_d = {res.sat, res.value[OUT_W-1:0]};
    end

    neuron_pipe_reg #(
        .Width (OUT_W + 1)
    ) u_s2 (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (s1_valid),
        .in_ready_o  (s2_ready),
        .in_data_i   (s2_data_d),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (s2_data_q)
    );

    assign sat_flag = s2_data_q[OUT_W];
    assign act_out  = s2_data_q[OUT_W-1:0];

    // Counts delivered saturated samples only; sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (out_valid && out_ready && sat_flag && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_cnt = cnt_q;

endmodule

// File: tb/tb_neuron_act.sv
// Self-checking bench for neuron_act: directed vectors, backpressure, reset, counter saturation,
// and randomized traffic against an integer reference model.
module tb_neuron_act;

    localparam int SHIFT = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic signed [15:0] acc_in;
    logic signed [15:0] bias;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] act_out;
    logic              sat_flag;
    logic [15:0]       sat_cnt;

    logic              s_in_valid;
    logic              s_in_ready;
    logic signed [15:0] s_acc;
    logic signed [15:0] s_bias;
    logic              s_out_valid;
    logic              s_out_ready;
    logic signed [7:0] s_act;
    logic              s_sat;
    logic [1:0]        s_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    neuron_act #(.ACC_W(16), .OUT_W(8), .SHIFT(SHIFT), .CNT_W(16)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .acc_in    (acc_in),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .act_out   (act_out),
        .sat_flag  (sat_flag),
        .sat_cnt   (sat_cnt)
    );

    neuron_act #(.ACC_W(16), .OUT_W(8), .SHIFT(SHIFT), .CNT_W(2)) u_sat (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .acc_in    (s_acc),
        .bias      (s_bias),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .act_out   (s_act),
        .sat_flag  (s_sat),
        .sat_cnt   (s_cnt)
    );

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Reference: floor((sum + half) / 2^SHIFT), optional ReLU, then clip to int8.
    function automatic void model(input int acc, input int b, output int val, output bit sat);
        int n;
        int q;
        n = acc + b + (1 << (SHIFT - 1));
        q = n / (1 << SHIFT);
        if (n < 0 && (n % (1 << SHIFT)) != 0) q = q - 1;
`ifdef NEURON_ACT_RELU_EN
        if (q < 0) q = 0;
`endif
        sat = 1'b0;
        val = q;
        if (q > 127) begin
            val = 127;
            sat = 1'b1;
        end else if (q < -128) begin
            val = -128;
            sat = 1'b1;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int acc;
        int b;
        int exp_val;
        bit exp_sat;
    } vec_t;

    vec_t vecs[$];
    int   exp_cnt;
    int   exp_q[$];
    bit   exp_sq[$];

    initial begin
        int  accepted;
        int  got[$];
        int  got_cyc[$];
        int  held;
        int  mv;
        bit  ms;
        bit  stall_prev;
        int  prev_act;
        bit  prev_sat;
        int  ev;
        bit  es;

        vecs.push_back('{16129, 0, 127, 1'b1});
        vecs.push_back('{100, 28, 2, 1'b0});
        vecs.push_back('{31, 0, 0, 1'b0});
        vecs.push_back('{32, 0, 1, 1'b0});
        vecs.push_back('{95, 0, 1, 1'b0});
        vecs.push_back('{-32, 0, 0, 1'b0});
        vecs.push_back('{32767, 32767, 127, 1'b1});
`ifdef NEURON_ACT_RELU_EN
        vecs.push_back('{-254, 0, 0, 1'b0});
        vecs.push_back('{-96, 0, 0, 1'b0});
        vecs.push_back('{-16384, 0, 0, 1'b0});
        vecs.push_back('{-32768, -32768, 0, 1'b0});
`else
        vecs.push_back('{-254, 0, -4, 1'b0});
        vecs.push_back('{-96, 0, -1, 1'b0});
        vecs.push_back('{-16384, 0, -128, 1'b1});
        vecs.push_back('{-32768, -32768, -128, 1'b1});
`endif

        rst = 1'b1;
        in_valid = 1'b0;
        acc_in = '0;
        bias = '0;
        out_ready = 1'b0;
        s_in_valid = 1'b0;
        s_acc = '0;
        s_bias = '0;
        s_out_ready = 1'b1;
        step();
        step();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_act_out", int'(act_out), 0);
        chk("rst_sat_flag", int'(sat_flag), 0);
        chk("rst_sat_cnt", int'(sat_cnt), 0);
        rst = 1'b0;
        step();
        chk("rst_in_ready", int'(in_ready), 1);

        // Directed vectors, one at a time with latency check.
        exp_cnt = 0;
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            in_valid = 1'b1;
            acc_in = 16'(vecs[i].acc);
            bias = 16'(vecs[i].b);
            step();
            in_valid = 1'b0;
            bias = 16'h1234;
            chk($sformatf("vec%0d_lat1_valid", i), int'(out_valid), 0);
            step();
            chk($sformatf("vec%0d_valid", i), int'(out_valid), 1);
            chk($sformatf("vec%0d_act", i), int'(act_out), vecs[i].exp_val);
            chk($sformatf("vec%0d_sat", i), int'(sat_flag), int'(vecs[i].exp_sat));
            if (vecs[i].exp_sat) exp_cnt++;
            step();
            chk($sformatf("vec%0d_cnt", i), int'(sat_cnt), exp_cnt);
        end

        // Backpressure: only two samples fit with out_ready low.
        out_ready = 1'b0;
        accepted = 0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            acc_in = 16'(64 * (accepted + 1));
            bias = '0;
            @(negedge clk);
            if (in_ready) accepted++;
            step();
        end
        chk("bp_accepted", accepted, 2);
        @(negedge clk);
        chk("bp_in_ready", int'(in_ready), 0);
        held = act_out;
        chk("bp_held_val", held, 1);
        step();
        step();
        chk("bp_stable_valid", int'(out_valid), 1);
        chk("bp_stable_act", int'(act_out), held);
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_valid) begin
                got.push_back(int'(act_out));
                got_cyc.push_back(c);
            end
            if (in_valid && in_ready) accepted++;
            step();
            if (accepted >= 4) in_valid = 1'b0;
            else acc_in = 16'(64 * (accepted + 1));
        end
        chk("bp_count", got.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < got.size()) chk($sformatf("bp_order%0d", k), got[k], k + 1);
        end
        if (got.size() == 4) chk("bp_one_per_cycle", got_cyc[3] - got_cyc[0], 3);

        // Reset with two saturating samples in flight.
        out_ready = 1'b0;
        in_valid = 1'b1;
        acc_in = 16'sd16129;
        step();
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_sat_cnt", int'(sat_cnt), 0);
        chk("mid_rst_in_ready", int'(in_ready), 1);
        out_ready = 1'b1;
        in_valid = 1'b1;
        acc_in = 16'sd192;
        step();
        in_valid = 1'b0;
        chk("post_rst_lat1", int'(out_valid), 0);
        step();
        chk("post_rst_valid", int'(out_valid), 1);
        chk("post_rst_act", int'(act_out), 3);
        step();

        // Randomized traffic against the model.
        exp_cnt = 0;
        stall_prev = 1'b0;
        prev_act = 0;
        prev_sat = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (int'(sat_cnt) != exp_cnt) chk("rnd_sat_cnt", int'(sat_cnt), exp_cnt);
            if (stall_prev) begin
                chk("rnd_hold_valid", int'(out_valid), 1);
                chk("rnd_hold_act", int'(act_out), prev_act);
                chk("rnd_hold_sat", int'(sat_flag), int'(prev_sat));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_unexpected_output", 1, 0);
                end else begin
                    ev = exp_q.pop_front();
                    es = exp_sq.pop_front();
                    chk("rnd_act", int'(act_out), ev);
                    chk("rnd_sat", int'(sat_flag), int'(es));
                    if (es && exp_cnt < 65535) exp_cnt++;
                end
            end
            if (in_valid && in_ready) begin
                model(int'(acc_in), int'(bias), mv, ms);
                exp_q.push_back(mv);
                exp_sq.push_back(ms);
            end
            stall_prev = out_valid && !out_ready;
            prev_act = act_out;
            prev_sat = sat_flag;
            step();
            if (c < 2980) begin
                in_valid = ($urandom_range(0, 9) < 7);
                out_ready = ($urandom_range(0, 9) < 6);
            end else begin
                in_valid = 1'b0;
                out_ready = 1'b1;
            end
            if ($urandom_range(0, 1) == 0) begin
                acc_in = 16'($urandom);
                bias = 16'($urandom);
            end else begin
                acc_in = 16'($urandom_range(0, 8000) - 4000);
                bias = 16'($urandom_range(0, 400) - 200);
            end
        end
        chk("rnd_drained", exp_q.size(), 0);
        chk("rnd_final_cnt", int'(sat_cnt), exp_cnt);

        // Two-bit counter sticks at its maximum.
        s_in_valid = 1'b1;
        s_acc = 16'sd16129;
        s_bias = '0;
        for (int c = 0; c < 5; c++) step();
        s_in_valid = 1'b0;
        step();
        step();
        step();
        chk("cnt_sat_value", int'(s_cnt), 3);
        chk("cnt_sat_idle", int'(s_out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
